cmp_scheduler: RTL and testbench
================================

CMP_SCHEDULER -- requirements
Module: cmp_scheduler

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the comparator.
REQ-002 Parameter NBYTES, default 4, SHALL set the operand width in bytes; each operand is 8*NBYTES bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset; reset is synchronous and active-high.
REQ-005 req_valid  input  NREQ  SHALL flag that requester i holds a compare request.
REQ-006 req_ready  output  NREQ  SHALL be one-hot or zero, and SHALL mark acceptance of requester i.
REQ-007 req_a, req_b  input  NREQ x 8*NBYTES  SHALL carry the operand pair of each requester.
REQ-008 rsp_valid  output  1  SHALL flag a valid result.
REQ-009 rsp_ready  input  1  SHALL flag that the consumer accepts the result.
REQ-010 rsp_id  output  $clog2(NREQ)  SHALL give the index of the requester being answered.
REQ-011 rsp_equal  output  1  SHALL be 1 if all bytes compared equal.
REQ-012 rsp_idx  output  $clog2(NBYTES)  SHALL give the first mismatching byte index, or 0 when equal.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CMP and RESP.
REQ-015 IDLE behaviour:
- Grant goes round-robin among asserted req_valid, starting at the pointer.
- req_ready[grant] is driven combinationally in the same cycle.
- On that cycle the block latches the operands and grant, clears the byte index and mismatch flag, and moves to CMP.
REQ-016 CMP SHALL compare one byte per cycle (byte 0 first) through one shared 8-bit comparator.
REQ-017 A byte whose comparison is not exactly true SHALL count as a mismatch, including any X or Z result in simulation; rsp_equal SHALL never be X.
REQ-018 On the first mismatch, CMP SHALL record its byte index; later mismatches SHALL NOT overwrite it.
REQ-019 CMP SHALL go to RESP after byte NBYTES-1 is compared.
REQ-020 RESP behaviour:
- rsp_valid, rsp_id, rsp_equal and rsp_idx are registered and held stable until rsp_valid && rsp_ready.
- On that handshake the FSM returns to IDLE and the pointer becomes grant+1, wrapping NREQ-1 to 0.
REQ-021 Full-length latency SHALL be NBYTES+1 cycles: accept at cycle T gives rsp_valid at T+NBYTES+1.
REQ-022 Requests arriving in CMP or RESP SHALL wait; req_ready stays 0 outside IDLE.
REQ-023 A new grant SHALL NOT be issued in the same cycle as the response handshake; the earliest next accept is the following cycle.
REQ-024 Deasserting req_valid before acceptance SHALL withdraw the request without side effects.

Reset
REQ-025 When rst is high at a clock edge:
- state becomes IDLE and the pointer 0;
- rsp_valid, rsp_equal, rsp_id and rsp_idx become 0;
- busy and req_ready become 0.
REQ-026 Reset SHALL take priority over every transition; reset in CMP or RESP SHALL discard the in-flight compare without producing a response.

Configuration
REQ-027 With macro CMP_EARLY_EXIT_EN defined, CMP SHALL go to RESP in the cycle after the first mismatching byte k, so rsp_valid appears at T+k+2.
REQ-028 Without CMP_EARLY_EXIT_EN, every compare SHALL take the full NBYTES cycles regardless of mismatches.

Structure
REQ-029 Package cmp_pkg SHALL hold:
- the state enum type;
- default constants NREQ_DEF=4 and NBYTES_DEF=4;
- a byte_t typedef (logic [7:0]).
REQ-030 Sub-module cmp8 SHALL hold the 8-bit equality comparator, with X treated as not-equal; cmp_scheduler SHALL instantiate exactly one cmp8.

Verification
REQ-031 Equal operands:
- Stimulus: req_valid=0001, a=b=32'hF0F0_0101, rsp_ready=1.
- Response: req_ready=0001 at T; rsp_valid at T+5 with rsp_id=0, rsp_equal=1, rsp_idx=0.
REQ-032 Mismatch in byte 1:
- Stimulus: a=32'h0000_0100, b=32'h0000_0000.
- Response: rsp_equal=0, rsp_idx=1; rsp_valid at T+3 with CMP_EARLY_EXIT_EN, else at T+5.
REQ-033 X operand bits:
- Stimulus: a=b=32'hxx00_0000 (byte 3 upper bits X).
- Response: rsp_equal=0 (not X), rsp_idx=3.
REQ-034 Round-robin fairness:
- Stimulus: req_valid=1111 held, rsp_ready=1.
- Response: grants in order 0,1,2,3,0; no requester is granted twice while another waits.
REQ-035 Backpressure:
- Stimulus: rsp_ready=0 for 6 cycles after rsp_valid, with other requests pending.
- Response: outputs stable, req_ready=0 throughout; the next grant comes one cycle after the handshake.
REQ-036 Reset mid-compare:
- Stimulus: rst=1 for one cycle during CMP.
- Response: next cycle busy=0, rsp_valid=0, pointer 0; no response is emitted for the aborted request.

Source files
------------

// File: rtl/cmp_scheduler_pkg.sv
// Shared types and defaults for the comparator scheduler (package cmp_pkg).
package cmp_pkg;

    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned NBYTES_DEF = 4;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_scheduler_if.sv
// Request/response bundle between requesters, consumer and the comparator scheduler.
interface cmp_scheduler_if #(
    parameter int unsigned NREQ   = cmp_pkg::NREQ_DEF,
    parameter int unsigned NBYTES = cmp_pkg::NBYTES_DEF
);
    localparam int unsigned ID_W  = cmp_pkg::idx_width(NREQ);
    localparam int unsigned IDX_W = cmp_pkg::idx_width(NBYTES);
    localparam int unsigned OP_W  = 8 * NBYTES;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][OP_W-1:0]  req_a;
    logic [NREQ-1:0][OP_W-1:0]  req_b;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic                       rsp_equal;
    logic [IDX_W-1:0]           rsp_idx;
    logic                       busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_equal, rsp_idx, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_equal, rsp_idx, busy
    );

endinterface

// File: rtl/cmp_scheduler_cmp8.sv
// Single 8-bit equality comparator; any unknown result reads as not-equal.
module cmp8
    import cmp_pkg::*;
(
    input  byte_t a_i,
    input  byte_t b_i,
    output logic  eq_c
);

    // An X/Z condition takes the else path, so eq_c is never X.
    always_comb begin
        eq_c = 1'b0;
        if (a_i == b_i) begin
            eq_c = 1'b1;
        end
    end

endmodule

// File: rtl/cmp_scheduler.sv
// Round-robin scheduler sharing one byte-serial comparator among NREQ requesters.
// Optional feature: define CMP_EARLY_EXIT_EN to end a compare right after the first mismatching byte.
module cmp_scheduler
    import cmp_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEF,
    parameter int unsigned NBYTES = NBYTES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    cmp_scheduler_if.slave  bus
);

    localparam int unsigned ID_W  = idx_width(NREQ);
    localparam int unsigned IDX_W = idx_width(NBYTES);
    localparam int unsigned CW    = ID_W + 1;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    byte_t [NBYTES-1:0]      a_q, a_d;
    byte_t [NBYTES-1:0]      b_q, b_d;
    logic [IDX_W-1:0]        byte_q, byte_d;
    logic                    mis_q, mis_d;
    logic [IDX_W-1:0]        mis_idx_q, mis_idx_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
    logic                    rsp_equal_q, rsp_equal_d;
    logic [IDX_W-1:0]        rsp_idx_q, rsp_idx_d;

    logic [ID_W-1:0]         grant_c;
    logic                    found_c;
    logic [CW-1:0]           cand_c;
    logic [NREQ-1:0]         req_ready_c;
    logic                    eq_c;
    logic                    last_c;
    logic                    done_c;

    // The one shared comparator looks at the current byte of the latched operands.
    cmp8 u_cmp8 (
        .a_i  (a_q[byte_q]),
        .b_i  (b_q[byte_q]),
        .eq_c (eq_c)
    );

    // Round-robin pick: first asserted requester at or after the pointer.
    always_comb begin
        grant_c = ptr_q;
        found_c = 1'b0;
        cand_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand_c = {1'b0, ptr_q} + CW'(i);
            if (cand_c >= CW'(NREQ)) begin
                cand_c = cand_c - CW'(NREQ);
            end
            if (!found_c && bus.req_valid[cand_c[ID_W-1:0]]) begin
                found_c = 1'b1;
                grant_c = cand_c[ID_W-1:0];
            end
        end
    end

    // Next-state, datapath and response updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        a_d         = a_q;
        b_d         = b_q;
        byte_d      = byte_q;
        mis_d       = mis_q;
        mis_idx_d   = mis_idx_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_equal_d = rsp_equal_q;
        rsp_idx_d   = rsp_idx_q;
        req_ready_c = '0;
        last_c      = 1'b0;
        done_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found_c && !rst) begin
                    req_ready_c[grant_c] = 1'b1;
                    grant_d   = grant_c;
                    a_d       = bus.req_a[grant_c];
                    b_d       = bus.req_b[grant_c];
                    byte_d    = '0;
                    mis_d     = 1'b0;
                    mis_idx_d = '0;
                    state_d   = CMP;
                end
            end

            CMP: begin
                if (!eq_c && !mis_q) begin
                    mis_d     = 1'b1;
                    mis_idx_d = byte_q;
                end
                last_c = (byte_q == IDX_W'(NBYTES - 1));
`ifdef CMP_EARLY_EXIT_EN
                done_c = last_c || !eq_c;
`else
                done_c = last_c;
`endif
                if (done_c) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = grant_q;
                    rsp_equal_d = eq_c && !mis_q;
                    if (mis_q) begin
                        rsp_idx_d = mis_idx_q;
                    end else if (!eq_c) begin
                        rsp_idx_d = byte_q;
                    end else begin
                        rsp_idx_d = '0;
                    end
                end else begin
                    byte_d = byte_q + IDX_W'(1);
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    ptr_d       = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            byte_q      <= '0;
            mis_q       <= 1'b0;
            mis_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_equal_q <= 1'b0;
            rsp_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            a_q         <= a_d;
            b_q         <= b_d;
            byte_q      <= byte_d;
            mis_q       <= mis_d;
            mis_idx_q   <= mis_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_equal_q <= rsp_equal_d;
            rsp_idx_q   <= rsp_idx_d;
        end
    end

    // Outputs: acceptance is combinational, everything else comes from registers.
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_equal = rsp_equal_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_scheduler.sv
// Directed self-checking bench for cmp_scheduler (NREQ=4, NBYTES=4).
module tb_cmp_scheduler;

    localparam int NR = 4;
    localparam int NB = 4;
    localparam int FULL_LAT = NB + 1;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    cmp_scheduler_if #(.NREQ(NR), .NBYTES(NB)) bus ();

    cmp_scheduler #(.NREQ(NR), .NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency from accept to rsp_valid when byte k is the first mismatch.
    function automatic int mis_lat(input int k);
`ifdef CMP_EARLY_EXIT_EN
        return k + 2;
`else
        return FULL_LAT + 0 * k;
`endif
    endfunction

    // Accept in the current cycle, then wait for and check the response.
    task automatic do_txn(input int exp_id, input int exp_lat, input logic exp_eq,
                          input int exp_idx, input bit drop);
        int  n;
        bit  got;
        logic [NR-1:0] onehot;
        onehot = '0;
        onehot[exp_id] = 1'b1;
        check("grant", 32'(bus.req_ready), 32'(onehot));
        n   = 0;
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            step();
            if (drop && c == 1) bus.req_valid = '0;
            settle();
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1;
                n   = c;
            end
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
        check("rsp_equal", 32'(bus.rsp_equal), 32'(exp_eq));
        check("rsp_idx", 32'(bus.rsp_idx), 32'(exp_idx));
        check("ready_in_resp", 32'(bus.req_ready), 32'h0);
    endtask

    initial begin
        bit any_rsp;
        int id;
        tests  = 0;
        failed = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i] = '0;
            bus.req_b[i] = '0;
        end
        step();
        step();
        rst = 1'b0;
        settle();
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_equal", 32'(bus.rsp_equal), 32'h0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("rst_rsp_idx", 32'(bus.rsp_idx), 32'h0);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);

        // Equal operands on requester 0.
        step();
        bus.req_valid = 4'b0001;
        bus.req_a[0]  = 32'hF0F0_0101;
        bus.req_b[0]  = 32'hF0F0_0101;
        bus.rsp_ready = 1'b1;
        settle();
        do_txn(0, FULL_LAT, 1'b1, 0, 1'b1);
        check("busy_in_resp", 32'(bus.busy), 32'h1);
        step();
        settle();
        check("post_hs_valid", 32'(bus.rsp_valid), 32'h0);
        check("post_hs_busy", 32'(bus.busy), 32'h0);

        // Mismatch in byte 1 on requester 1 (pointer now 1).
        bus.req_valid = 4'b0010;
        bus.req_a[1]  = 32'h0000_0100;
        bus.req_b[1]  = 32'h0000_0000;
        settle();
        do_txn(1, mis_lat(1), 1'b0, 1, 1'b1);
        step();

        // Unknown upper bits in byte 3; low nibble still differs.
        bus.req_valid = 4'b0100;
        bus.req_a[2]  = 32'hx100_0000;
        bus.req_b[2]  = 32'hx000_0000;
        settle();
        do_txn(2, mis_lat(3), 1'b0, 3, 1'b1);
        step();

        // Reset again, then round-robin with all requesters held.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_a[0] = 32'h1234_5678; bus.req_b[0] = 32'h1234_5678;
        bus.req_a[1] = 32'hDEAD_BEEF; bus.req_b[1] = 32'hDEAD_BEEF;
        bus.req_a[2] = 32'h0000_0000; bus.req_b[2] = 32'h0000_0000;
        bus.req_a[3] = 32'h00AB_0000; bus.req_b[3] = 32'h0000_0000;
        bus.req_valid = 4'b1111;
        settle();
        for (int k = 0; k < 5; k++) begin
            id = k % NR;
            if (id == 3) do_txn(id, mis_lat(2), 1'b0, 2, 1'b0);
            else         do_txn(id, FULL_LAT, 1'b1, 0, 1'b0);
            step();
            settle();
        end

        // Backpressure on requester 1 with others still pending.
        bus.rsp_ready = 1'b0;
        do_txn(1, FULL_LAT, 1'b1, 0, 1'b0);
        for (int h = 0; h < 6; h++) begin
            step();
            settle();
            check("bp_valid", 32'(bus.rsp_valid), 32'h1);
            check("bp_id", 32'(bus.rsp_id), 32'h1);
            check("bp_equal", 32'(bus.rsp_equal), 32'h1);
            check("bp_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.rsp_ready = 1'b1;
        step();
        settle();
        check("bp_hs_valid", 32'(bus.rsp_valid), 32'h0);
        check("bp_next_grant", 32'(bus.req_ready), 32'h4);

        // Reset in the middle of requester 2's compare.
        step();
        bus.req_valid = '0;
        settle();
        check("cmp_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_valid", 32'(bus.rsp_valid), 32'h0);
        any_rsp = 1'b0;
        for (int w = 0; w < 8; w++) begin
            step();
            settle();
            if (bus.rsp_valid !== 1'b0) any_rsp = 1'b1;
        end
        check("abort_no_rsp", 32'(any_rsp), 32'h0);

        // Pointer back to 0: with requesters 0 and 3 pending, 0 wins.
        bus.req_valid = 4'b1001;
        settle();
        do_txn(0, FULL_LAT, 1'b1, 0, 1'b1);

        // A request raised and withdrawn while in RESP leaves no trace.
        bus.req_valid = 4'b0010;
        settle();
        check("resp_ready_zero", 32'(bus.req_ready), 32'h0);
        bus.req_valid = '0;
        step();
        settle();
        check("wd_busy", 32'(bus.busy), 32'h0);
        check("wd_valid", 32'(bus.rsp_valid), 32'h0);
        step();
        settle();
        check("wd_busy2", 32'(bus.busy), 32'h0);
        check("wd_ready", 32'(bus.req_ready), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
